// File: rtl/store_retire_buffer.sv
// Store retire buffer.
// Retired stores from up to N_WAY lanes per cycle are collected in a small
// circular FIFO and drained one at a time to a word-wide memory write port.
// A completion pulse goes back to the store queue once memory acknowledges
// each write. Completions are issued strictly in enqueue order.
module store_retire_buffer #(
  parameter int N_WAY = 2,   // retire lanes per cycle
  parameter int N_SQ  = 8,   // store queue entries
  parameter int DEPTH = 4,   // buffer entries (power of two, >= N_WAY)
  parameter int XLEN  = 32   // address and data width
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_WAY-1:0]                 ret_valid,
  input  logic [N_WAY-1:0][XLEN-1:0]       ret_addr,
  input  logic [N_WAY-1:0][XLEN-1:0]       ret_data,
  input  logic [N_WAY-1:0][1:0]            ret_size,
  input  logic [N_WAY-1:0][$clog2(N_SQ):0] ret_store_pos,
  output logic [$clog2(DEPTH):0]           free_slots,
  output logic                             mem_wr_en,
  output logic [XLEN-1:0]                  mem_wr_addr,
  output logic [XLEN-1:0]                  mem_wr_data,
  output logic [3:0]                       mem_wr_be,
  input  logic                             mem_wr_ack,
  output logic                             done_valid,
  output logic [$clog2(N_SQ):0]            done_store_pos,
  output logic                             err_overflow,
  output logic                             err_align
);

  localparam int AW = $clog2(DEPTH);      // pointer width
  localparam int CW = $clog2(DEPTH) + 1;  // occupancy width (0..DEPTH)
  localparam int PW = $clog2(N_SQ) + 1;   // store queue position width
  localparam int RW = $clog2(N_WAY) + 1;  // per-lane rank width

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Entry storage (contents are not reset; only pointers/count are)
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [1:0]      size_mem [DEPTH];
  logic [PW-1:0]   pos_mem  [DEPTH];

  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  state_t state_reg, state_next;
  logic   load_issue;
  logic   pop;

  // ---------------------------------------------------------------------
  // Lane acceptance: each valid lane gets a rank equal to the number of
  // valid lanes below it. Lanes whose rank reaches the free space seen at
  // the start of the cycle are dropped, so the highest lanes go first.
  // ---------------------------------------------------------------------
  logic [N_WAY-1:0][RW-1:0] lane_rank;
  logic [N_WAY-1:0][AW-1:0] lane_wr_idx;
  logic [N_WAY-1:0]         lane_accept;
  logic [CW-1:0]            push_count;
  logic                     any_drop;

  generate
    for (genvar gi = 0; gi < N_WAY; gi++) begin : g_lane
      localparam logic [N_WAY-1:0] LOWER_MASK = N_WAY'((64'd1 << gi) - 64'd1);

      assign lane_rank[gi]   = RW'($countones(ret_valid & LOWER_MASK));
      assign lane_accept[gi] = ret_valid[gi] && (int'(lane_rank[gi]) < int'(free_slots));
      assign lane_wr_idx[gi] = tail_reg + AW'(lane_rank[gi]);
    end
  endgenerate

  assign free_slots = CW'(DEPTH) - count_reg;
  assign push_count = CW'($countones(lane_accept));
  assign any_drop   = |(ret_valid & ~lane_accept);

  // Pop happens on the edge where memory accepts the in-flight write.
  assign pop = (state_reg == ISSUE) && mem_wr_ack;

  // Pointer and occupancy update: pushes and a pop may land on the same edge.
  always_comb begin
    tail_next  = tail_reg + AW'(push_count);
    head_next  = head_reg + AW'(pop);
    count_next = count_reg + push_count - CW'(pop);
  end

  // Write accepted lanes into consecutive slots starting at the tail.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (lane_accept[i]) begin
        addr_mem[lane_wr_idx[i]] <= ret_addr[i];
        data_mem[lane_wr_idx[i]] <= ret_data[i];
        size_mem[lane_wr_idx[i]] <= ret_size[i];
        pos_mem[lane_wr_idx[i]]  <= ret_store_pos[i];
      end
    end
  end

  // Head, tail and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------------
  // Head entry encoding into a word-wide write with byte enables.
  // Misaligned halves/words are still written with the same encoding;
  // they only raise the sticky alignment flag.
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] head_addr;
  logic [XLEN-1:0] head_data;
  logic [1:0]      head_size;
  logic [PW-1:0]   head_pos;
  logic [3:0]      enc_be;
  logic [XLEN-1:0] enc_data;
  logic            enc_misalign;

  // Decode the head entry into byte enables and lane-replicated data.
  always_comb begin
    head_addr    = addr_mem[head_reg];
    head_data    = data_mem[head_reg];
    head_size    = size_mem[head_reg];
    head_pos     = pos_mem[head_reg];
    enc_be       = 4'b1111;
    enc_data     = head_data;
    enc_misalign = 1'b0;
    case (head_size)
      SIZE_BYTE: begin
        enc_be   = 4'b0001 << head_addr[1:0];
        enc_data = {(XLEN/8){head_data[7:0]}};
      end
      SIZE_HALF: begin
        enc_be       = 4'b0011 << {head_addr[1], 1'b0};
        enc_data     = {(XLEN/16){head_data[15:0]}};
        enc_misalign = head_addr[0];
      end
      default: begin
        enc_misalign = (head_addr[1:0] != 2'b00);
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Drain FSM: IDLE -> ISSUE while entries exist, ISSUE holds until ack,
  // DONE emits the completion pulse and either re-issues or idles.
  // ---------------------------------------------------------------------

  // State register; reset also aborts an in-flight write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; load_issue marks edges that enter ISSUE.
  always_comb begin
    state_next = state_reg;
    load_issue = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          state_next = ISSUE;
          load_issue = 1'b1;
        end
      end
      ISSUE: begin
        if (mem_wr_ack) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (count_reg != '0) begin
          state_next = ISSUE;
          load_issue = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Issue registers: captured once when entering ISSUE so the write
  // fields stay stable for as long as memory stalls.
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] issue_addr_reg;
  logic [XLEN-1:0] issue_data_reg;
  logic [3:0]      issue_be_reg;
  logic [PW-1:0]   issue_pos_reg;
  logic [PW-1:0]   done_pos_reg;
  logic            err_align_reg;
  logic            err_overflow_reg;

  // Capture the encoded head entry on entry to ISSUE; flag misalignment.
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_addr_reg <= '0;
      issue_data_reg <= '0;
      issue_be_reg   <= '0;
      issue_pos_reg  <= '0;
      err_align_reg  <= 1'b0;
    end else if (load_issue) begin
      issue_addr_reg <= {head_addr[XLEN-1:2], 2'b00};
      issue_data_reg <= enc_data;
      issue_be_reg   <= enc_be;
      issue_pos_reg  <= head_pos;
      if (enc_misalign) begin
        err_align_reg <= 1'b1;
      end
    end
  end

  // Remember the popped entry's store queue slot for the DONE pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      done_pos_reg <= '0;
    end else if (pop) begin
      done_pos_reg <= issue_pos_reg;
    end
  end

  // Sticky overflow flag, set whenever any valid lane is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_overflow_reg <= 1'b0;
    end else if (any_drop) begin
      err_overflow_reg <= 1'b1;
    end
  end

  assign mem_wr_en      = (state_reg == ISSUE);
  assign mem_wr_addr    = issue_addr_reg;
  assign mem_wr_data    = issue_data_reg;
  assign mem_wr_be      = issue_be_reg;
  assign done_valid     = (state_reg == DONE);
  assign done_store_pos = done_pos_reg;
  assign err_overflow   = err_overflow_reg;
  assign err_align      = err_align_reg;

endmodule

// File: tb/tb_store_retire_buffer.sv
// Self-checking bench for store_retire_buffer.
// Expected writes/completions go into a scoreboard queue as stores are
// driven; a negedge monitor compares every accepted write and every
// completion against it. A vector table covers the encoding cases and
// hand-written sequences cover the multi-cycle corner cases.
module tb_store_retire_buffer;

  logic                  clock;
  logic                  reset;
  logic [1:0]            ret_valid;
  logic [1:0][31:0]      ret_addr;
  logic [1:0][31:0]      ret_data;
  logic [1:0][1:0]       ret_size;
  logic [1:0][3:0]       ret_store_pos;
  logic [2:0]            free_slots;
  logic                  mem_wr_en;
  logic [31:0]           mem_wr_addr;
  logic [31:0]           mem_wr_data;
  logic [3:0]            mem_wr_be;
  logic                  mem_wr_ack;
  logic                  done_valid;
  logic [3:0]            done_store_pos;
  logic                  err_overflow;
  logic                  err_align;

  store_retire_buffer #(
    .N_WAY(2), .N_SQ(8), .DEPTH(4), .XLEN(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ret_valid(ret_valid),
    .ret_addr(ret_addr),
    .ret_data(ret_data),
    .ret_size(ret_size),
    .ret_store_pos(ret_store_pos),
    .free_slots(free_slots),
    .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be),
    .mem_wr_ack(mem_wr_ack),
    .done_valid(done_valid),
    .done_store_pos(done_store_pos),
    .err_overflow(err_overflow),
    .err_align(err_align)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [3:0]  pos;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [3:0]  pos;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;
    logic        exp_align;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_lanes();
    ret_valid     = '0;
    ret_addr      = '0;
    ret_data      = '0;
    ret_size      = '0;
    ret_store_pos = '0;
  endtask

  task automatic drive(input int l, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic [3:0] p);
    ret_valid[l]     = 1'b1;
    ret_addr[l]      = a;
    ret_data[l]      = d;
    ret_size[l]      = s;
    ret_store_pos[l] = p;
  endtask

  // Aligned word store that is expected to be accepted and written as-is.
  task automatic put_word(input int l, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] p);
    drive(l, a, d, 2'd2, p);
    exp_q.push_back(exp_t'{a, 4'hF, d, p});
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    mem_wr_ack = 1'b0;
    clear_lanes();
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Wait (bounded) for ISSUE, stall wait_cycles, then ack; ends in DONE.
  task automatic serve(input int wait_cycles, input string tag);
    int guard = 0;
    while (!mem_wr_en && guard < 20) begin
      tick();
      guard++;
    end
    if (!mem_wr_en) begin
      chk_cnt++;
      $display("FAIL %s_timeout: got mem_wr_en=0 expected 1 within 20 cycles", tag);
    end
    for (int i = 0; i < wait_cycles; i++) begin
      check({tag, "_hold_en"}, 32'(mem_wr_en), 32'd1);
      tick();
    end
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack = 1'b0;
    check({tag, "_done"}, 32'(done_valid), 32'd1);
  endtask

  // Scoreboard monitor: accepted writes, stall stability, completions.
  logic        prev_wait;
  logic [31:0] prev_addr;
  logic [31:0] prev_data;
  logic [3:0]  prev_be;
  initial prev_wait = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      if (prev_wait && mem_wr_en) begin
        check("stable_addr", mem_wr_addr, prev_addr);
        check("stable_data", mem_wr_data, prev_data);
        check("stable_be", 32'(mem_wr_be), 32'(prev_be));
      end
      if (mem_wr_en && mem_wr_ack) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL wr_unexpected: got write to %h expected none", mem_wr_addr);
        end else begin
          check("wr_addr", mem_wr_addr, exp_q[0].addr);
          check("wr_data", mem_wr_data, exp_q[0].data);
          check("wr_be", 32'(mem_wr_be), 32'(exp_q[0].be));
        end
      end
      if (done_valid) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL done_unexpected: got pos %0d expected none", done_store_pos);
        end else begin
          check("done_pos", 32'(done_store_pos), 32'(exp_q[0].pos));
          void'(exp_q.pop_front());
        end
      end
    end
    prev_wait <= mem_wr_en && !mem_wr_ack && !reset;
    prev_addr <= mem_wr_addr;
    prev_data <= mem_wr_data;
    prev_be   <= mem_wr_be;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h100, 32'hDEADBEEF, 2'd2, 4'd3, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{32'h203, 32'h0000005A, 2'd0, 4'd1, 32'h200, 4'b1000, 32'h5A5A5A5A, 1'b0};
    vecs[2] = '{32'h202, 32'h00001234, 2'd1, 4'd2, 32'h200, 4'b1100, 32'h12341234, 1'b0};
    vecs[3] = '{32'h301, 32'h0000ABCD, 2'd1, 4'd5, 32'h300, 4'b0011, 32'hABCDABCD, 1'b1};
    vecs[4] = '{32'h40E, 32'hCAFEF00D, 2'd2, 4'd8, 32'h40C, 4'b1111, 32'hCAFEF00D, 1'b1};
    vecs[5] = '{32'h511, 32'hFFFFFF77, 2'd0, 4'd4, 32'h510, 4'b0010, 32'h77777777, 1'b0};

    reset      = 1'b1;
    mem_wr_ack = 1'b0;
    clear_lanes();
    do_reset();

    // Reset state
    check("rst_free", 32'(free_slots), 32'd4);
    check("rst_en", 32'(mem_wr_en), 32'd0);
    check("rst_done", 32'(done_valid), 32'd0);
    check("rst_pos", 32'(done_store_pos), 32'd0);
    check("rst_ovf", 32'(err_overflow), 32'd0);
    check("rst_align", 32'(err_align), 32'd0);

    // Single-store encoding and latency, ack held high throughout
    for (int i = 0; i < 6; i++) begin
      do_reset();
      mem_wr_ack = 1'b1;
      drive(0, vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].pos);
      exp_q.push_back(exp_t'{vecs[i].exp_addr, vecs[i].exp_be, vecs[i].exp_data, vecs[i].pos});
      tick();
      clear_lanes();
      check($sformatf("v%0d_t1_en", i), 32'(mem_wr_en), 32'd0);
      check($sformatf("v%0d_t1_free", i), 32'(free_slots), 32'd3);
      tick();
      check($sformatf("v%0d_t2_en", i), 32'(mem_wr_en), 32'd1);
      tick();
      check($sformatf("v%0d_t3_done", i), 32'(done_valid), 32'd1);
      check($sformatf("v%0d_t3_pos", i), 32'(done_store_pos), 32'(vecs[i].pos));
      check($sformatf("v%0d_align", i), 32'(err_align), 32'(vecs[i].exp_align));
      tick();
      check($sformatf("v%0d_t4_done", i), 32'(done_valid), 32'd0);
      check($sformatf("v%0d_t4_en", i), 32'(mem_wr_en), 32'd0);
      check($sformatf("v%0d_t4_free", i), 32'(free_slots), 32'd4);
      mem_wr_ack = 1'b0;
    end

    // Dual-lane order with a 3-cycle ack delay
    do_reset();
    put_word(0, 32'h600, 32'h11111111, 4'd1);
    put_word(1, 32'h604, 32'h22222222, 4'd2);
    tick();
    clear_lanes();
    check("dual_free2", 32'(free_slots), 32'd2);
    serve(3, "dual_a");
    tick();
    check("dual_pulse_end", 32'(done_valid), 32'd0);
    check("dual_reissue", 32'(mem_wr_en), 32'd1);
    serve(3, "dual_b");
    tick();
    check("dual_idle_done", 32'(done_valid), 32'd0);
    check("dual_free4", 32'(free_slots), 32'd4);
    check("dual_sb_empty", 32'(exp_q.size()), 32'd0);

    // Overflow when full, then drain across the pointer wrap
    do_reset();
    put_word(0, 32'h800, 32'hA0000001, 4'd1);
    put_word(1, 32'h804, 32'hA0000002, 4'd2);
    tick();
    clear_lanes();
    put_word(0, 32'h808, 32'hA0000003, 4'd3);
    put_word(1, 32'h80C, 32'hA0000004, 4'd4);
    tick();
    clear_lanes();
    check("ovf_full_free", 32'(free_slots), 32'd0);
    check("ovf_pre", 32'(err_overflow), 32'd0);
    drive(0, 32'h810, 32'hBAD00005, 2'd2, 4'd5);
    drive(1, 32'h814, 32'hBAD00006, 2'd2, 4'd6);
    tick();
    clear_lanes();
    check("ovf_flag", 32'(err_overflow), 32'd1);
    check("ovf_free0", 32'(free_slots), 32'd0);
    serve(0, "wrap_1");
    check("wrap_free1", 32'(free_slots), 32'd1);
    put_word(0, 32'h818, 32'hA0000007, 4'd7);
    tick();
    clear_lanes();
    check("wrap_refill", 32'(free_slots), 32'd0);
    serve(0, "wrap_2");
    serve(0, "wrap_3");
    serve(0, "wrap_4");
    serve(0, "wrap_5");
    tick();
    check("wrap_free4", 32'(free_slots), 32'd4);
    check("wrap_ovf_sticky", 32'(err_overflow), 32'd1);
    check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Push and pop on the same edge keep occupancy unchanged
    do_reset();
    put_word(0, 32'h900, 32'hC0000001, 4'd1);
    put_word(1, 32'h904, 32'hC0000002, 4'd2);
    tick();
    clear_lanes();
    put_word(0, 32'h908, 32'hC0000003, 4'd3);
    tick();
    clear_lanes();
    check("pp_free1", 32'(free_slots), 32'd1);
    check("pp_issue", 32'(mem_wr_en), 32'd1);
    mem_wr_ack = 1'b1;
    put_word(0, 32'h90C, 32'hC0000004, 4'd4);
    tick();
    clear_lanes();
    mem_wr_ack = 1'b0;
    check("pp_free_same", 32'(free_slots), 32'd1);
    check("pp_done", 32'(done_valid), 32'd1);
    check("pp_no_ovf", 32'(err_overflow), 32'd0);
    tick();
    check("pp_no_ovf_next", 32'(err_overflow), 32'd0);
    serve(0, "pp_2");
    serve(0, "pp_3");
    serve(0, "pp_4");
    tick();
    check("pp_free4", 32'(free_slots), 32'd4);
    check("pp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset while a write is stalled in ISSUE, with both flags set
    do_reset();
    drive(0, 32'h702, 32'hD0000001, 2'd2, 4'd1);
    drive(1, 32'h708, 32'hD0000002, 2'd2, 4'd2);
    tick();
    clear_lanes();
    drive(0, 32'h70C, 32'hD0000003, 2'd2, 4'd3);
    drive(1, 32'h710, 32'hD0000004, 2'd2, 4'd4);
    tick();
    clear_lanes();
    drive(0, 32'h714, 32'hD0000005, 2'd2, 4'd5);
    drive(1, 32'h718, 32'hD0000006, 2'd2, 4'd6);
    tick();
    clear_lanes();
    check("mid_en", 32'(mem_wr_en), 32'd1);
    check("mid_align", 32'(err_align), 32'd1);
    check("mid_ovf", 32'(err_overflow), 32'd1);
    check("mid_wr_addr", mem_wr_addr, 32'h700);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("mrst_en", 32'(mem_wr_en), 32'd0);
    check("mrst_free", 32'(free_slots), 32'd4);
    check("mrst_align", 32'(err_align), 32'd0);
    check("mrst_ovf", 32'(err_overflow), 32'd0);
    check("mrst_done", 32'(done_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mrst_idle_en%0d", i), 32'(mem_wr_en), 32'd0);
      check($sformatf("mrst_idle_done%0d", i), 32'(done_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
